button_event_detector: RTL
==========================

BUTTON_EVENT_DETECTOR -- requirements
Module: button_event_detector

Interface
- REQ-001 Parameter N_CH, default 4: number of independent button channels (1..32).
- REQ-002 Parameter DB_CYCLES, default 4: consecutive stable synchronised cycles needed to accept a level change (>=1).
- REQ-003 Parameter LONG_CYCLES, default 16: debounced-held cycles after which a press counts as long (>=2).
- REQ-004 Parameter REPEAT_CYCLES, default 8: auto-repeat period in LONG state (>=1).
- REQ-005 clk  input  1  single clock; all state changes on its rising edge.
- REQ-006 reset_n  input  1  asynchronous, active-low reset.
- REQ-007 btn_raw  input  N_CH  asynchronous raw button levels, 1 = pressed.
- REQ-008 held  output  N_CH  debounced pressed level per channel.
- REQ-009 click  output  N_CH  one-cycle pulse on release of a short press.
- REQ-010 long_press  output  N_CH  one-cycle pulse when a hold reaches LONG_CYCLES.
- REQ-011 repeat_tick  output  N_CH  one-cycle pulse every REPEAT_CYCLES while in LONG.

Function
- REQ-012 Each btn_raw bit SHALL pass through a 2-flop synchroniser before any other logic.
- REQ-013 Per-channel debounce counter SHALL increment while the synchronised value differs from held, clear on any cycle they match, and flip held when it reaches DB_CYCLES-1 (counter then clears).
- REQ-014 A glitch shorter than DB_CYCLES synchronised cycles SHALL NOT change held or produce any pulse.
- REQ-015 Per-channel FSM states SHALL be UNPRESSED, PRESSED, LONG.
- REQ-016 UNPRESSED->PRESSED when held rises; hold counter cleared on entry.
- REQ-017 In PRESSED the hold counter SHALL increment each cycle; on reaching LONG_CYCLES-1 with held still 1, move to LONG and assert long_press for exactly the next cycle.
- REQ-018 PRESSED->UNPRESSED when held falls; click SHALL be asserted for exactly the next cycle.
- REQ-019 LONG->UNPRESSED when held falls; no click SHALL be generated.
- REQ-020 If held falls on the same cycle the hold counter reaches LONG_CYCLES-1, release wins: click pulses, long_press does not.
- REQ-021 All pulse outputs SHALL be registered; at most one of click/long_press per channel per cycle.
- REQ-022 Counters SHALL be sized $clog2 of their limit and never wrap; channels SHALL be fully independent.

Reset
- REQ-023 While reset_n is low: synchronisers, counters cleared; state UNPRESSED; held, click, long_press, repeat_tick all 0, asynchronously.
- REQ-024 Reset asserted mid-press SHALL abort the press with no pulse; after release of reset a still-pressed button SHALL re-qualify through full synchronisation and debounce.

Configuration
- REQ-025 Macro BUTTON_REPEAT_EN defined: in LONG a repeat counter SHALL pulse repeat_tick every REPEAT_CYCLES cycles, first tick REPEAT_CYCLES cycles after long_press, stopping when LONG is left.
- REQ-026 Macro BUTTON_REPEAT_EN undefined: repeat_tick SHALL be constant 0 and no repeat counter SHALL exist.

Structure
- REQ-027 Package button_pkg SHALL hold the FSM state enum and default values of DB_CYCLES, LONG_CYCLES, REPEAT_CYCLES.
- REQ-028 Sub-module button_debounce (one channel: synchroniser + debounce, output held) SHALL be instantiated N_CH times by generate.

Verification
- REQ-029 Reset then btn_raw[0] high 6 cycles, low: held[0] rises after 2+DB_CYCLES cycles, one click[0] pulse after release, no long_press.
- REQ-030 btn_raw[1] high 2 cycles (glitch, DB_CYCLES=4): held, click, long_press remain 0.
- REQ-031 btn_raw[2] high 40 cycles: long_press[2] one pulse LONG_CYCLES cycles after held rises; no click on release; with BUTTON_REPEAT_EN, ticks at +8, +16 after long_press until release.
- REQ-032 All channels pressed simultaneously, released on different cycles: each channel's click independent, correct per-channel timing.
- REQ-033 reset_n low mid-press for 3 cycles with button still high: all outputs 0 during reset, no click, held re-rises 2+DB_CYCLES cycles after reset release.
- REQ-034 Release timed so held falls on the LONG threshold cycle: click pulses, long_press stays 0.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and parameter defaults for the button event detector.
package button_pkg;

  typedef enum logic [1:0] {
    ST_UNPRESSED = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG      = 2'd2
  } btn_state_t;

  localparam int DB_CYCLES_DEF     = 4;
  localparam int LONG_CYCLES_DEF   = 16;
  localparam int REPEAT_CYCLES_DEF = 8;

  // Counter width for a limit; a counter never exceeds limit-1, so $clog2 suffices.
  function automatic int cnt_w(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/button_event_detector_if.sv
// Button-side signal bundle: raw levels in, debounced level and event pulses out.
interface button_event_detector_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn_raw;
  logic [N_CH-1:0] held;
  logic [N_CH-1:0] click;
  logic [N_CH-1:0] long_press;
  logic [N_CH-1:0] repeat_tick;

  modport master (
    output btn_raw,
    input  held, click, long_press, repeat_tick
  );

  modport slave (
    input  btn_raw,
    output held, click, long_press, repeat_tick
  );
endinterface

// File: rtl/button_debounce.sv
// One channel: 2-flop synchroniser followed by a stability-count debouncer.
module button_debounce
  import button_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic held,
  output logic held_nxt
);

  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic sync1, sync2;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt_q <= '0;
      held  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      cnt_q <= cnt_d;
      held  <= held_nxt;
    end
  end

  // held_nxt is exported so the event FSM reacts on the same edge held changes.
  always_comb begin
    cnt_d    = '0;
    held_nxt = held;
    if (sync2 != held) begin
      if (cnt_q == CNT_LAST) begin
        held_nxt = sync2;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_event_detector.sv
// N_CH-channel button debouncer with click / long-press / auto-repeat events.
// Optional macro BUTTON_REPEAT_EN enables the repeat_tick generator in LONG.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_UNPRESSED | debounced level low, waiting for a press
// ST_PRESSED   | held high, hold counter running toward LONG_CYCLES
// ST_LONG      | long press reported, waiting for release (repeats if enabled)
module button_event_detector
  import button_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  button_event_detector_if.slave  bus
);

  localparam int LW = cnt_w(LONG_CYCLES);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);

  if (N_CH < 1 || N_CH > 32 || DB_CYCLES < 1 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1)
  begin : g_bad_param
    $error("button_event_detector: parameter out of range");
  end

  logic [N_CH-1:0] held_v, click_v, long_v, tick_v;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic          held_nxt;
    btn_state_t    state_q, state_d;
    logic [LW-1:0] hold_q, hold_d;
    logic          click_q, click_d;
    logic          long_q, long_d;

    button_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_raw  (bus.btn_raw[g]),
      .held     (held_v[g]),
      .held_nxt (held_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= ST_UNPRESSED;
        hold_q  <= '0;
        click_q <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        click_q <= click_d;
        long_q  <= long_d;
      end
    end

    // Release is tested before the long threshold so a coincident release wins.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      click_d = 1'b0;
      long_d  = 1'b0;
      case (state_q)
        ST_UNPRESSED: begin
          if (held_nxt) begin
            state_d = ST_PRESSED;
            hold_d  = '0;
          end
        end
        ST_PRESSED: begin
          if (!held_nxt) begin
            state_d = ST_UNPRESSED;
            click_d = 1'b1;
          end else if (hold_q == HOLD_LAST) begin
            state_d = ST_LONG;
            long_d  = 1'b1;
          end else begin
            hold_d = hold_q + LW'(1);
          end
        end
        ST_LONG: begin
          if (!held_nxt) begin
            state_d = ST_UNPRESSED;
          end
        end
        default: begin
          state_d = ST_UNPRESSED;
          hold_d  = '0;
        end
      endcase
    end

`ifdef BUTTON_REPEAT_EN
    localparam int RW = cnt_w(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_q, rep_d;
    logic          tick_q, tick_d;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rep_q  <= '0;
        tick_q <= 1'b0;
      end else begin
        rep_q  <= rep_d;
        tick_q <= tick_d;
      end
    end

    // Counter sits at zero outside LONG, so the first tick lands REPEAT_CYCLES after entry.
    always_comb begin
      rep_d  = '0;
      tick_d = 1'b0;
      if (state_q == ST_LONG && held_nxt) begin
        if (rep_q == REP_LAST) begin
          tick_d = 1'b1;
        end else begin
          rep_d = rep_q + RW'(1);
        end
      end
    end

    assign tick_v[g] = tick_q;
`else
    assign tick_v[g] = 1'b0;
`endif

    assign click_v[g] = click_q;
    assign long_v[g]  = long_q;
  end

  assign bus.held        = held_v;
  assign bus.click       = click_v;
  assign bus.long_press  = long_v;
  assign bus.repeat_tick = tick_v;

endmodule
